// File: rtl/comp_pipe_arbiter_pkg.sv
// comp_arb_pkg: shared clog2 helper, tag width and flush FSM state type for comp_pipe_arbiter
package comp_arb_pkg;
  localparam int TAG_W = 4;
  typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/comp_pipe_arbiter_picker.sv
// comp_rr_picker: combinational round-robin pick (req, ptr in; one-hot grant, index, any out), search starts at ptr+1
module comp_rr_picker
  import comp_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [TAG_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [TAG_W-1:0]   idx,
  output logic               any
);
  logic [TAG_W:0] s;
  always_comb begin
    grant = '0;
    idx = '0;
    any = 1'b0;
    s = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      s = {1'b0, ptr} + (TAG_W + 1)'(k);
      s = s >= (TAG_W + 1)'(NUM_REQ) ? s - (TAG_W + 1)'(NUM_REQ) : s;
      if (!any && |(req & (NUM_REQ'(1) << s))) begin
        any = 1'b1;
        idx = s[TAG_W-1:0];
      end
    end
    grant = any ? NUM_REQ'(1) << idx : '0;
  end
endmodule

// File: rtl/comp_pipe_arbiter.sv
// comp_pipe_arbiter: round-robin share of a fixed-latency pipe; ports clk/rst, req_valid/req_data/req_ready, pipe_in_*/pipe_out_data, rsp_valid/rsp_data, flush/flush_done; COMP_ARB_GRANT_CNT_EN adds grant_cnt
module comp_pipe_arbiter
  import comp_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = 64,
  parameter int RES_W    = 64,
  parameter int PIPE_LAT = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      pipe_in_valid,
  output logic [DATA_W-1:0]         pipe_in_data,
  input  logic [RES_W-1:0]          pipe_out_data,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [RES_W-1:0]          rsp_data,
  input  logic                      flush,
  output logic                      flush_done
`ifdef COMP_ARB_GRANT_CNT_EN
  ,
  output logic [NUM_REQ*32-1:0]     grant_cnt
`endif
);
  localparam int CW = clog2(PIPE_LAT + 2);
  state_t state, state_nxt;
  logic [TAG_W-1:0] rr_ptr, idx, pipe_in_tag;
  logic [TAG_W-1:0] dl_tag [PIPE_LAT];
  logic [PIPE_LAT-1:0] dl_v;
  logic [NUM_REQ-1:0] grant;
  logic [CW-1:0] inflight, inflight_nxt;
  logic any, run, accept, rsp;
  comp_rr_picker #(.NUM_REQ(NUM_REQ)) u_pick (
    .req  (req_valid),
    .ptr  (rr_ptr),
    .grant(grant),
    .idx  (idx),
    .any  (any)
  );
  always_comb begin
    run = state == RUN && !flush && !rst;
    flush_done = state == HALT && !rst;
  end
  assign accept = run && any;
  assign req_ready = run ? grant : '0;
  assign rsp = dl_v[PIPE_LAT-1] && !rst;
  assign rsp_valid = rsp ? NUM_REQ'(1) << dl_tag[PIPE_LAT-1] : '0;
  assign rsp_data = pipe_out_data;
  assign inflight_nxt = inflight + CW'(accept) - CW'(rsp);
  // Halting on the post-update count lets flush_done rise the cycle after the last result.
  always_comb begin
    state_nxt = state == RUN   ? (flush ? (inflight_nxt == '0 ? HALT : DRAIN) : RUN) :
                state == DRAIN ? (inflight_nxt == '0 ? HALT : DRAIN) :
                                 (flush ? HALT : RUN);
  end
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else state <= state_nxt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= TAG_W'(NUM_REQ - 1);
      pipe_in_valid <= 1'b0;
      pipe_in_data <= '0;
      pipe_in_tag <= '0;
      dl_v <= '0;
      inflight <= '0;
      for (int k = 0; k < PIPE_LAT; k++) dl_tag[k] <= '0;
    end else begin
      pipe_in_valid <= accept;
      inflight <= inflight_nxt;
      dl_v[0] <= pipe_in_valid;
      dl_tag[0] <= pipe_in_tag;
      for (int k = 1; k < PIPE_LAT; k++) begin
        dl_v[k] <= dl_v[k-1];
        dl_tag[k] <= dl_tag[k-1];
      end
      if (accept) begin
        rr_ptr <= idx;
        pipe_in_tag <= idx;
        pipe_in_data <= DATA_W'(req_data >> (DATA_W * int'(idx)));
      end
    end
  end
`ifdef COMP_ARB_GRANT_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) grant_cnt <= '0;
    else for (int i = 0; i < NUM_REQ; i++)
      if (accept && idx == TAG_W'(i)) grant_cnt[i*32 +: 32] <= grant_cnt[i*32 +: 32] + 32'd1;
  end
`endif
endmodule

// File: tb/tb_comp_pipe_arbiter.sv
// tb_comp_pipe_arbiter: directed and random checks of comp_pipe_arbiter against a queue-based reference model
module tb_comp_pipe_arbiter;
  localparam int N = 4, DW = 64, RW = 64, PL = 3;
  typedef struct {int tag; int due;} ent_t;
  logic clk, rst, flush, flush_done, pipe_in_valid;
  logic [N-1:0] req_valid, req_ready, rsp_valid;
  logic [N*DW-1:0] req_data;
  logic [DW-1:0] pipe_in_data;
  logic [RW-1:0] pipe_out_data, rsp_data;
`ifdef COMP_ARB_GRANT_CNT_EN
  logic [N*32-1:0] grant_cnt;
`endif
  ent_t q[$];
  int m_ptr, m_state, cyc, checks, errors;
  logic m_piv;
  logic [DW-1:0] m_pid;
  logic [31:0] m_cnt [N];
  logic [N-1:0] exp_ready, exp_rsp;
  logic exp_done;
  comp_pipe_arbiter #(.NUM_REQ(N), .DATA_W(DW), .RES_W(RW), .PIPE_LAT(PL)) dut (
`ifdef COMP_ARB_GRANT_CNT_EN
    .grant_cnt(grant_cnt),
`endif
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .pipe_in_valid(pipe_in_valid), .pipe_in_data(pipe_in_data), .pipe_out_data(pipe_out_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .flush(flush), .flush_done(flush_done)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic int pick();
    for (int k = 1; k <= N; k++) if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction
  task automatic drive(input logic [N-1:0] v, input logic f, input logic r);
    req_valid = v;
    flush = f;
    rst = r;
    for (int i = 0; i < N * DW / 32; i++) req_data[i*32 +: 32] = $urandom();
    pipe_out_data = {$urandom(), $urandom()};
  endtask
  task automatic sample();
    int g;
    @(negedge clk);
    g = (m_state == 0 && !flush && !rst) ? pick() : -1;
    exp_ready = g < 0 ? '0 : N'(1) << g;
    exp_rsp = (!rst && q.size() > 0 && q[0].due == cyc) ? N'(1) << q[0].tag : '0;
    exp_done = m_state == 2 && !rst;
  endtask
  task automatic advance();
    int g;
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_ptr = N - 1;
      m_state = 0;
      m_piv = 1'b0;
      m_pid = '0;
      foreach (m_cnt[i]) m_cnt[i] = '0;
    end else begin
      g = (m_state == 0 && !flush) ? pick() : -1;
      if (q.size() > 0 && q[0].due == cyc) void'(q.pop_front());
      m_piv = g >= 0;
      if (g >= 0) begin
        m_pid = req_data[g*DW +: DW];
        m_ptr = g;
        q.push_back(ent_t'{g, cyc + 1 + PL});
        m_cnt[g] = m_cnt[g] + 32'd1;
      end
      m_state = m_state == 0 ? (flush ? (q.size() == 0 ? 2 : 1) : 0) :
                m_state == 1 ? (q.size() == 0 ? 2 : 1) : (flush ? 2 : 0);
    end
    cyc++;
    #1;
  endtask
  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      drive(N'($urandom()), 1'b0, 1'b1);
      sample();
      checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_ready got=%b exp=0", req_ready); end
      checks++; if (rsp_valid !== '0) begin errors++; $display("FAIL reset_rsp got=%b exp=0", rsp_valid); end
      checks++; if (flush_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", flush_done); end
      advance();
    end
    drive('0, 1'b0, 1'b0);
    sample();
    checks++; if (pipe_in_valid !== 1'b0) begin errors++; $display("FAIL reset_piv got=%b exp=0", pipe_in_valid); end
    checks++; if (pipe_in_data !== '0) begin errors++; $display("FAIL reset_pid got=%h exp=0", pipe_in_data); end
    advance();
  endtask
  task automatic test_round_robin();
    logic [N-1:0] want;
    for (int k = 0; k < 12; k++) begin
      drive(k < 5 ? 4'hF : 4'h0, 1'b0, 1'b0);
      sample();
      want = k < 5 ? N'(1) << (k % 4) : '0;
      checks++; if (req_ready !== want || req_ready !== exp_ready) begin errors++; $display("FAIL rr_ready k=%0d got=%b exp=%b", k, req_ready, want); end
      want = (k >= 4 && k <= 8) ? N'(1) << ((k - 4) % 4) : '0;
      checks++; if (rsp_valid !== want || rsp_valid !== exp_rsp) begin errors++; $display("FAIL rr_rsp k=%0d got=%b exp=%b", k, rsp_valid, want); end
      checks++; if (pipe_in_valid !== (k >= 1 && k <= 5)) begin errors++; $display("FAIL rr_piv k=%0d got=%b", k, pipe_in_valid); end
      advance();
    end
  endtask
  task automatic test_single();
    for (int k = 0; k < 11; k++) begin
      drive(k < 5 ? 4'b0100 : 4'b0000, 1'b0, 1'b0);
      req_data[2*DW +: DW] = DW'(16 + k);
      sample();
      checks++; if (req_ready !== (k < 5 ? 4'b0100 : 4'b0000)) begin errors++; $display("FAIL single_ready k=%0d got=%b", k, req_ready); end
      if (k >= 1 && k <= 5) begin
        checks++; if (pipe_in_data !== DW'(15 + k) || pipe_in_valid !== 1'b1) begin errors++; $display("FAIL single_pid k=%0d got=%h exp=%h", k, pipe_in_data, 15 + k); end
      end
      checks++; if (rsp_valid !== ((k >= 4 && k <= 8) ? 4'b0100 : 4'b0000)) begin errors++; $display("FAIL single_rsp k=%0d got=%b", k, rsp_valid); end
      if (rsp_valid != 0) begin
        checks++; if (rsp_data !== pipe_out_data) begin errors++; $display("FAIL single_rdata got=%h exp=%h", rsp_data, pipe_out_data); end
      end
      advance();
    end
  endtask
  task automatic test_flush_full();
    int last_rsp, done_at;
    last_rsp = -1;
    done_at = -1;
    for (int k = 0; k < 4; k++) begin
      drive(4'hF, 1'b0, 1'b0);
      sample();
      checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL fill_ready got=%b exp=%b", req_ready, exp_ready); end
      advance();
    end
    for (int k = 0; k < 15 && done_at < 0; k++) begin
      drive(4'hF, 1'b1, 1'b0);
      sample();
      checks++; if (req_ready !== '0) begin errors++; $display("FAIL flush_ready got=%b exp=0", req_ready); end
      checks++; if (rsp_valid !== exp_rsp) begin errors++; $display("FAIL flush_rsp got=%b exp=%b", rsp_valid, exp_rsp); end
      checks++; if (flush_done !== exp_done) begin errors++; $display("FAIL flush_done got=%b exp=%b", flush_done, exp_done); end
      if (exp_rsp != 0) last_rsp = cyc;
      if (flush_done === 1'b1) done_at = cyc;
      advance();
    end
    checks++; if (done_at < 0 || done_at != last_rsp + 1) begin errors++; $display("FAIL flush_timing got=%0d exp=%0d", done_at, last_rsp + 1); end
    drive(4'hF, 1'b1, 1'b0);
    sample();
    checks++; if (flush_done !== 1'b1 || req_ready !== '0) begin errors++; $display("FAIL halt_hold got=%b/%b exp=1/0", flush_done, req_ready); end
    advance();
    drive(4'hF, 1'b0, 1'b0);
    sample();
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL halt_exit_ready got=%b exp=0", req_ready); end
    advance();
    drive(4'hF, 1'b0, 1'b0);
    sample();
    checks++; if (req_ready !== exp_ready || exp_ready == '0) begin errors++; $display("FAIL resume_ready got=%b exp=%b", req_ready, exp_ready); end
    advance();
  endtask
  task automatic test_flush_idle();
    for (int k = 0; k < 6; k++) begin
      drive('0, 1'b0, 1'b0);
      sample();
      advance();
    end
    drive(4'hF, 1'b1, 1'b0);
    sample();
    checks++; if (req_ready !== '0 || flush_done !== 1'b0) begin errors++; $display("FAIL idle_flush got=%b/%b exp=0/0", req_ready, flush_done); end
    advance();
    drive(4'hF, 1'b1, 1'b0);
    sample();
    checks++; if (flush_done !== 1'b1) begin errors++; $display("FAIL idle_done got=%b exp=1", flush_done); end
    checks++; if (pipe_in_valid !== 1'b0) begin errors++; $display("FAIL idle_piv got=%b exp=0", pipe_in_valid); end
    advance();
    drive('0, 1'b0, 1'b0);
    sample();
    advance();
  endtask
  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++) begin
      drive(4'hF, 1'b0, 1'b0);
      sample();
      advance();
    end
    drive(4'hF, 1'b0, 1'b1);
    sample();
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL rstmid_ready got=%b exp=0", req_ready); end
    advance();
    for (int k = 0; k < PL + 3; k++) begin
      drive('0, 1'b0, 1'b0);
      sample();
      checks++; if (rsp_valid !== '0 || exp_rsp !== '0) begin errors++; $display("FAIL rstmid_rsp k=%0d got=%b exp=0", k, rsp_valid); end
      advance();
    end
    drive(4'hF, 1'b0, 1'b0);
    sample();
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rstmid_first got=%b exp=0001", req_ready); end
    advance();
  endtask
  task automatic test_random();
    logic f;
    f = 1'b0;
    for (int k = 0; k < 600; k++) begin
      f = f ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 19) == 0);
      drive(N'($urandom()), f, $urandom_range(0, 63) == 0);
      sample();
      checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, req_ready, exp_ready); end
      checks++; if (rsp_valid !== exp_rsp) begin errors++; $display("FAIL rnd_rsp cyc=%0d got=%b exp=%b", cyc, rsp_valid, exp_rsp); end
      checks++; if (flush_done !== exp_done) begin errors++; $display("FAIL rnd_done cyc=%0d got=%b exp=%b", cyc, flush_done, exp_done); end
      if (!rst) begin
        checks++; if (pipe_in_valid !== m_piv || pipe_in_data !== m_pid) begin errors++; $display("FAIL rnd_pipe_in cyc=%0d got=%b/%h exp=%b/%h", cyc, pipe_in_valid, pipe_in_data, m_piv, m_pid); end
      end
      if (exp_rsp != 0) begin
        checks++; if (rsp_data !== pipe_out_data) begin errors++; $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", cyc, rsp_data, pipe_out_data); end
      end
`ifdef COMP_ARB_GRANT_CNT_EN
      if (!rst) for (int i = 0; i < N; i++) begin
        checks++; if (grant_cnt[i*32 +: 32] !== m_cnt[i]) begin errors++; $display("FAIL rnd_cnt%0d got=%0d exp=%0d", i, grant_cnt[i*32 +: 32], m_cnt[i]); end
      end
`endif
      advance();
    end
  endtask
  initial begin
    checks = 0;
    errors = 0;
    cyc = 0;
    m_ptr = N - 1;
    m_state = 0;
    m_piv = 1'b0;
    m_pid = '0;
    foreach (m_cnt[i]) m_cnt[i] = '0;
    rst = 1'b1;
    flush = 1'b0;
    req_valid = '0;
    req_data = '0;
    pipe_out_data = '0;
    #6;
    test_reset();
    test_round_robin();
    test_single();
    test_flush_full();
    test_flush_idle();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
